// File: rtl/cbus_arbiter_rr_pkg.sv
// cbus_arbiter_rr_pkg: CBus request/response types and the arbiter state encoding.
package cbus_arbiter_rr_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} cbus_size_t;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} cbus_burst_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
    cbus_burst_t burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
  typedef enum logic {IDLE, BUSY} cbus_arb_state_t;
endpackage

// File: rtl/cbus_arbiter_rr_if.sv
// cbus_arbiter_rr_if: upstream request/response vectors plus the single downstream CBus link.
interface cbus_arbiter_rr_if
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS = 2
);
  cbus_req_t  [NUM_PORTS-1:0] ireqs;
  cbus_resp_t [NUM_PORTS-1:0] iresps;
  cbus_req_t                  oreq;
  cbus_resp_t                 oresp;
  modport master (output ireqs, input iresps, input oreq, output oresp);
  modport slave (input ireqs, output iresps, output oreq, input oresp);
endinterface

// File: rtl/cbus_arbiter_rr_rr_pick.sv
// cbus_arbiter_rr_rr_pick: combinational winner search, rotating from a pointer or fixed from index 0.
module cbus_arbiter_rr_rr_pick #(
  parameter int NUM_PORTS   = 2,
  parameter bit ROUND_ROBIN = 1'b1,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_valid,
  input  logic [IDX_W-1:0]     i_rr_ptr,
  output logic [IDX_W-1:0]     o_winner,
  output logic                 o_found
);
  logic [IDX_W-1:0] w_base;

  function automatic logic [IDX_W-1:0] wrap(int v);
    return IDX_W'(v % NUM_PORTS);
  endfunction

  assign w_base  = ROUND_ROBIN ? i_rr_ptr : '0;
  assign o_found = |i_valid;

  // Scan farthest offset first so the nearest valid port is the final write.
  always_comb begin
    o_winner = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (i_valid[wrap(k + int'(w_base))]) o_winner = wrap(k + int'(w_base));
  end
endmodule

// File: rtl/cbus_arbiter_rr.sv
// cbus_arbiter_rr: N-to-1 CBus arbiter; fixed or round-robin priority, grant held for a whole burst.
module cbus_arbiter_rr
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter bit ROUND_ROBIN = 1'b1,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  cbus_arbiter_rr_if.slave           bus,
  output logic                       o_busy,
  output logic [IDX_W-1:0]           o_grant_idx,
  output logic [NUM_PORTS-1:0][31:0] o_grant_cnt
);
  cbus_arb_state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]           r_grant_idx, r_rr_ptr, w_winner;
  logic [NUM_PORTS-1:0][31:0] r_grant_cnt;
  logic [NUM_PORTS-1:0]       w_valid;
  logic                       w_found, w_done;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_valid[i] = bus.ireqs[i].valid;
  end

  cbus_arbiter_rr_rr_pick #(.NUM_PORTS(NUM_PORTS), .ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .i_valid (w_valid),
    .i_rr_ptr(r_rr_ptr),
    .o_winner(w_winner),
    .o_found (w_found)
  );

  assign w_done      = r_state == BUSY && bus.oresp.ready && bus.oresp.last;
  assign w_state_nxt = w_done ? IDLE : (r_state == IDLE && w_found) ? BUSY : r_state;
  assign bus.oreq    = r_state == BUSY ? bus.ireqs[r_grant_idx] : '0;

  always_comb begin
    bus.iresps = '0;
    if (r_state == BUSY) bus.iresps[r_grant_idx] = bus.oresp;
  end

  // Completion and the pointer update land on the same edge, so the next IDLE cycle sees the new pointer.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_grant_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) r_grant_idx <= w_winner;
      if (w_done && ~&r_grant_cnt[r_grant_idx]) r_grant_cnt[r_grant_idx] <= r_grant_cnt[r_grant_idx] + 32'd1;
      if (w_done && ROUND_ROBIN) r_rr_ptr <= r_grant_idx == IDX_W'(NUM_PORTS - 1) ? '0 : r_grant_idx + 1'b1;
    end

  assign o_busy      = r_state == BUSY;
  assign o_grant_idx = r_grant_idx;
  assign o_grant_cnt = r_grant_cnt;

  // The owner must hold valid for its whole burst; the grant is kept either way.
  a_owner_valid : assert property (@(posedge i_clk) disable iff (!i_rst_n) r_state == BUSY |-> bus.ireqs[r_grant_idx].valid)
    else $warning("cbus_arbiter_rr: owner %0d dropped valid mid-burst", r_grant_idx);
endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// tb_cbus_arbiter_rr: random and directed stimulus for a 3-port round-robin arbiter, checked against a transaction-level model.
module tb_cbus_arbiter_rr;
  import cbus_arbiter_rr_pkg::*;
  localparam int NP = 3;
  localparam int IW = $clog2(NP);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                busy;
  logic [IW-1:0]       gidx;
  logic [NP-1:0][31:0] gcnt;
  cbus_req_t [NP-1:0]  t_req;
  logic                t_rdy;
  int                  m_owner, m_beat, m_ptr;
  logic [31:0]         m_cnt [NP];
  bit                  m_done [NP];
  int                  total = 0;
  int                  bad = 0;

  cbus_arbiter_rr_if #(.NUM_PORTS(NP)) bus ();

  cbus_arbiter_rr #(.NUM_PORTS(NP), .ROUND_ROBIN(1'b1)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_busy     (busy),
    .o_grant_idx(gidx),
    .o_grant_cnt(gcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_beat  = 0;
    m_ptr   = 0;
    for (int i = 0; i < NP; i++) begin
      m_cnt[i]  = '0;
      m_done[i] = 1'b0;
    end
  endtask

  function automatic cbus_req_t mk(int len);
    cbus_req_t q;
    q.valid    = 1'b1;
    q.is_write = 1'($urandom);
    q.size     = cbus_size_t'($urandom_range(0, 2));
    q.addr     = $urandom;
    q.strobe   = 4'($urandom);
    q.data     = $urandom;
    q.len      = 8'(len);
    q.burst    = cbus_burst_t'($urandom_range(0, 2));
    return q;
  endfunction

  function automatic bit any_v();
    bit v = 1'b0;
    for (int i = 0; i < NP; i++) v |= t_req[i].valid;
    return v;
  endfunction

  // Winner = valid port at the smallest rotational distance from the pointer.
  function automatic int pick();
    int w = -1;
    for (int i = 0; i < NP; i++)
      if (t_req[i].valid && (w < 0 || (i - m_ptr + NP) % NP < (w - m_ptr + NP) % NP)) w = i;
    return w;
  endfunction

  task automatic gen(bit en);
    for (int i = 0; i < NP; i++)
      if (m_done[i]) begin
        t_req[i].valid = 1'b0;
        m_done[i] = 1'b0;
      end else if (en && !t_req[i].valid && $urandom_range(0, 2) == 0) t_req[i] = mk($urandom_range(0, 7));
    t_rdy = $urandom_range(0, 3) != 0;
  endtask

  task automatic cycle();
    cbus_resp_t r;
    @(negedge clk);
    bus.ireqs = t_req;
    r.ready = t_rdy;
    r.last = t_rdy && (m_owner < 0 ? 1'b1 : m_beat == int'(t_req[m_owner].len));
    r.data = $urandom;
    bus.oresp = r;
    #1;
    chk("busy", 128'(busy), 128'(m_owner >= 0));
    if (m_owner >= 0) begin
      chk("grant_idx", 128'(gidx), 128'(m_owner));
      chk("oreq", 128'(bus.oreq), 128'(t_req[m_owner]));
    end else chk("oreq_idle", 128'(bus.oreq), 128'(0));
    for (int i = 0; i < NP; i++) begin
      chk("iresp", 128'(bus.iresps[i]), i == m_owner ? 128'(r) : 128'(0));
      chk("grant_cnt", 128'(gcnt[i]), 128'(m_cnt[i]));
    end
    if (m_owner < 0) begin
      m_owner = pick();
      m_beat = 0;
    end else if (r.ready) begin
      if (r.last) begin
        if (m_cnt[m_owner] != 32'hFFFF_FFFF) m_cnt[m_owner]++;
        m_done[m_owner] = 1'b1;
        m_ptr = (m_owner + 1) % NP;
        m_owner = -1;
      end else m_beat++;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      gen(1'b0);
      cycle();
      if (m_owner < 0 && !any_v()) break;
    end
    cycle();
    chk("drain_idle", 128'(busy), 128'(0));
  endtask

  initial begin
    rst_n = 1'b1;
    t_req = '0;
    t_rdy = 1'b0;
    bus.ireqs = '0;
    bus.oresp = '0;
    m_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_gidx", 128'(gidx), 128'(0));
    chk("rst_oreq", 128'(bus.oreq), 128'(0));
    chk("rst_iresps", 128'(bus.iresps), 128'(0));
    chk("rst_gcnt", 128'(gcnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (400) begin
      gen(1'b1);
      cycle();
    end
    drain();
    // pointer wrap: port 1 completes (ptr=2), then ports 0 and 1 contend
    t_rdy = 1'b1;
    t_req[1] = mk(0);
    cycle();
    cycle();
    t_req[0] = mk(0);
    cycle();
    cycle();
    chk("t5_wrap_grant", 128'(gidx), 128'(0));
    cycle();
    cycle();
    chk("t5_ptr_after", 128'(gidx), 128'(1));
    t_req[1].valid = 1'b0;
    drain();
    // long burst on port 2 with port 0 arriving mid-burst
    t_rdy = 1'b1;
    t_req[2] = mk(7);
    cycle();
    for (int b = 0; b < 8; b++) begin
      if (b == 3) t_req[0] = mk(0);
      cycle();
      chk("t4_owner", 128'(gidx), 128'(2));
      chk("t4_p0_ready", 128'(bus.iresps[0].ready), 128'(0));
    end
    t_req[2].valid = 1'b0;
    cycle();
    chk("t4_bubble", 128'(busy), 128'(0));
    cycle();
    chk("t4_p0_grant", 128'({busy, gidx}), 128'({1'b1, 2'd0}));
    drain();
    // all ports continuously requesting single beats, pointer starts at 1
    t_rdy = 1'b1;
    for (int i = 0; i < NP; i++) t_req[i] = mk(0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t3_bubble", 128'(busy), 128'(0));
      cycle();
      chk("t3_order", 128'(gidx), 128'((k + 1) % NP));
    end
    t_req = '0;
    drain();
    // owner drops valid mid-burst: grant still held until ready&&last
    t_rdy = 1'b1;
    t_req[1] = mk(3);
    cycle();
    cycle();
    cycle();
    t_req[1].valid = 1'b0;
    cycle();
    chk("t6_hold", 128'({busy, gidx}), 128'({1'b1, 2'd1}));
    chk("t6_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    cycle();
    chk("t6_last_held", 128'({busy, gidx}), 128'({1'b1, 2'd1}));
    cycle();
    chk("t6_idle", 128'(busy), 128'(0));
    drain();
    // asynchronous reset in the middle of a burst
    t_rdy = 1'b1;
    t_req[1] = mk(3);
    cycle();
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("t1_busy", 128'(busy), 128'(0));
    chk("t1_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    for (int i = 0; i < NP; i++) chk("t1_ready", 128'(bus.iresps[i].ready), 128'(0));
    chk("t1_gcnt", 128'(gcnt), 128'(0));
    t_req = '0;
    bus.ireqs = t_req;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t_req[1] = mk(0);
    t_req[2] = mk(0);
    cycle();
    cycle();
    chk("t1_ptr_reset", 128'(gidx), 128'(1));
    t_req = '0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
